// File: rtl/nibble_seq_ctrl_if.sv
// rtl/nibble_seq_ctrl_if.sv - request, result and external 4-bit adder signals of nibble_seq_ctrl
interface nibble_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         abort;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         nib_cin;
    logic [4:0]   nib_res;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    // The master issues requests and hosts the external adder; the slave is the sequencer.
    modport master (
        output start, abort, op_a, op_b, cin, nib_res,
        input  nib_a, nib_b, nib_cin, busy, done, sum, cout
    );

    modport slave (
        input  start, abort, op_a, op_b, cin, nib_res,
        output nib_a, nib_b, nib_cin, busy, done, sum, cout
    );
endinterface

// File: rtl/nibble_seq_ctrl.sv
// rtl/nibble_seq_ctrl.sv - W-bit adder sequenced one nibble per cycle through an external 4-bit adder
module nibble_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic              clk,
    input logic              rst_n,
    nibble_seq_ctrl_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          cin_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          last;
    logic          busy_c;
    logic          done_c;
    logic [3:0]    nib_a_c;
    logic [3:0]    nib_b_c;
    logic          nib_cin_c;

    assign last = (idx == IW'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and adder drive; the adder sees zeros whenever no slice is in flight.
    always_comb begin
        state_nx  = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        nib_a_c   = 4'd0;
        nib_b_c   = 4'd0;
        nib_cin_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy_c    = 1'b1;
                nib_a_c   = a_q[4*idx +: 4];
                nib_b_c   = b_q[4*idx +: 4];
                nib_cin_c = (idx == '0) ? cin_q : carry;
                // abort takes priority over completion and over any start seen in RUN
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = bus.start ? RUN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture on an accepted start, then one slice written per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state != RUN) begin
            if (bus.start) begin
                a_q   <= bus.op_a;
                b_q   <= bus.op_b;
                cin_q <= bus.cin;
                idx   <= '0;
            end
        end else if (!bus.abort) begin
            sum_q[4*idx +: 4] <= bus.nib_res[3:0];
            carry             <= bus.nib_res[4];
            idx               <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout_q <= bus.nib_res[4];
            end
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.nib_a   = nib_a_c;
    assign bus.nib_b   = nib_b_c;
    assign bus.nib_cin = nib_cin_c;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// tb/tb_nibble_seq_ctrl.sv - self-checking bench for nibble_seq_ctrl with a behavioural reference
module tb_nibble_seq_ctrl;
    localparam int NIB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    nibble_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

    nibble_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External 4-bit adder.
    assign bus.nib_res = {1'b0, bus.nib_a} + {1'b0, bus.nib_b} + {4'd0, bus.nib_cin};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0 idle, 1 run, 2 done; results from whole-word arithmetic.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_a     = 0;
    int          m_b     = 0;
    int          m_cin   = 0;
    logic [16:0] m_res   = '0;
    bit          m_known = 1'b0;
    bit          m_init  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_k     = 0;
            m_res   = '0;
            m_known = 1'b1;
            m_init  = 1'b1;
        end else if (m_init) begin
            if (m_phase == 1) begin
                if (bus.abort) begin
                    m_phase = 0;
                end else if (m_k == NIB - 1) begin
                    m_phase = 2;
                    m_res   = 17'(m_a + m_b + m_cin);
                    m_known = 1'b1;
                end else begin
                    m_k++;
                end
            end else if (bus.start) begin
                m_a     = int'(bus.op_a);
                m_b     = int'(bus.op_b);
                m_cin   = int'(bus.cin);
                m_k     = 0;
                m_phase = 1;
                m_known = 1'b0;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        int mask;
        int e_a;
        int e_b;
        int e_c;
        if (m_init) begin
            e_a = 0;
            e_b = 0;
            e_c = 0;
            if (m_phase == 1) begin
                mask = (1 << (4 * m_k)) - 1;
                e_a  = (m_a >> (4 * m_k)) & 15;
                e_b  = (m_b >> (4 * m_k)) & 15;
                e_c  = (((m_a & mask) + (m_b & mask) + m_cin) >> (4 * m_k)) & 1;
            end
            chk("m_busy", 32'(bus.busy), 32'(m_phase == 1));
            chk("m_done", 32'(bus.done), 32'(m_phase == 2));
            chk("m_nib_a", 32'(bus.nib_a), 32'(e_a));
            chk("m_nib_b", 32'(bus.nib_b), 32'(e_b));
            chk("m_nib_cin", 32'(bus.nib_cin), 32'(e_c));
            if (m_known) begin
                chk("m_sum", 32'(bus.sum), 32'(m_res[15:0]));
                chk("m_cout", 32'(bus.cout), 32'(m_res[16]));
            end
        end
    end

    int       busy_cnt;
    bit [3:0] cin_hist;

    // Called at negedge+1; counts edges until done is seen, recording the adder carry per RUN cycle.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) begin
                if (busy_cnt < 4) cin_hist[busy_cnt] = bus.nib_cin;
                busy_cnt++;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            #1;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 32'(bus.done), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, output int edges);
        int n;
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = 0;
        cin_hist  = '0;
        wait_done(n);
        edges = n + 1;
    endtask

    task automatic idle_cycles(input int count, output int dones);
        dones = 0;
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int n;
        int dones;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);

        // start held during reset is only accepted on the first edge out of reset
        bus.start = 1'b1;
        bus.op_a  = 16'h0002;
        bus.op_b  = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("start_in_rst", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("start_after_rst", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        busy_cnt  = 0;
        wait_done(n);
        chk("post_rst_sum", 32'(bus.sum), 32'h0005);

        // zeros: latency and busy length
        do_op(16'h0000, 16'h0000, 1'b0, edges);
        chk("zero_latency", 32'(edges), 32'd5);
        chk("zero_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("zero_sum", 32'(bus.sum), 32'h0000);
        chk("zero_cout", 32'(bus.cout), 32'd0);

        do_op(16'h1234, 16'h4321, 1'b1, edges);
        chk("mix_latency", 32'(edges), 32'd5);
        chk("mix_sum", 32'(bus.sum), 32'h5556);
        chk("mix_cout", 32'(bus.cout), 32'd0);

        do_op(16'hFFFF, 16'h0001, 1'b0, edges);
        chk("ripple_sum", 32'(bus.sum), 32'h0000);
        chk("ripple_cout", 32'(bus.cout), 32'd1);
        chk("ripple_cin_hist", 32'(cin_hist), 32'b1110);
        idle_cycles(1, dones);
        chk("ripple_hold_sum", 32'(bus.sum), 32'h0000);
        chk("ripple_hold_cout", 32'(bus.cout), 32'd1);
        chk("done_one_cycle", 32'(dones), 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = 16'h00E0;
        bus.op_b  = 16'h00A0;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = 16'hFFFF;
        bus.op_b  = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(n);
        chk("ignore_latency", 32'(n + 3), 32'd5);
        chk("ignore_sum", 32'(bus.sum), 32'h0180);
        chk("ignore_cout", 32'(bus.cout), 32'd0);

        // abort with a simultaneous start on the 3rd RUN cycle
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h1111;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_nib_a", 32'(bus.nib_a), 32'd0);
        idle_cycles(8, dones);
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);

        // reset in the middle of RUN
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_a  = 16'h0F0F;
        bus.op_b  = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_sum", 32'(bus.sum), 32'd0);
        chk("mrst_cout", 32'(bus.cout), 32'd0);
        chk("mrst_nibs", 32'({bus.nib_a, bus.nib_b, bus.nib_cin}), 32'd0);
        rst_n = 1'b1;
        idle_cycles(6, dones);
        chk("mrst_no_done", 32'(dones), 32'd0);

        // back-to-back: start high during DONE launches the next op at once
        do_op(16'h1111, 16'h2222, 1'b0, edges);
        chk("b2b_first_sum", 32'(bus.sum), 32'h3333);
        bus.start = 1'b1;
        bus.op_a  = 16'h000D;
        bus.op_b  = 16'h0006;
        bus.cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("b2b_run", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        busy_cnt  = 0;
        wait_done(n);
        chk("b2b_latency", 32'(n + 1), 32'd5);
        chk("b2b_sum", 32'(bus.sum), 32'h0013);
        chk("b2b_cout", 32'(bus.cout), 32'd0);

        idle_cycles(2, dones);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
